// File: rtl/scoreboard_regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Holds the default data width and register-index width.
package scoreboard_regfile_pkg;

  localparam int SB_WORD_WIDTH = 32;
  localparam int SB_ADDR_WIDTH = 5;

endpackage

// File: rtl/busy_popcount.sv
// Population count of a pending-bit vector.
// Feeds the registered busy count in the register file.
module busy_popcount
  import scoreboard_regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[k]);
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending bits and two write ports.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module scoreboard_regfile
  import scoreboard_regfile_pkg::*;
#(
  parameter int WORD_WIDTH = SB_WORD_WIDTH,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*WORD_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           wr0_en,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [WORD_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [WORD_WIDTH-1:0]          wr1_data,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic                           rsv_ready,
  input  logic                           flush,
  output logic [ADDR_WIDTH:0]            busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;

  // wr1 is assigned last so it wins an address collision with wr0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      if (wr0_en && wr0_addr != '0) begin
        regs_q[wr0_addr] <= wr0_data;
      end
      if (wr1_en && wr1_addr != '0) begin
        regs_q[wr1_addr] <= wr1_data;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr1_en) begin
        busy_d[wr1_addr] = 1'b0;
      end
      if (rsv_en) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  busy_popcount #(
    .WIDTH (DEPTH),
    .CNT_W (ADDR_WIDTH + 1)
  ) u_popcount (
    .vec_i (busy_d),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt  = cnt_q;
  assign rsv_ready = (rsv_addr == '0) || !busy_q[rsv_addr];

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [WORD_WIDTH-1:0] data;
    logic                  bsy;

    assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = (ra == '0) ? '0 : regs_q[ra];
      bsy  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (ra != '0) begin
        if (wr1_en && wr1_addr == ra) begin
          data = wr1_data;
        end else if (wr0_en && wr0_addr == ra) begin
          data = wr0_data;
        end
        if (wr1_en && wr1_addr == ra && !(rsv_en && rsv_addr == ra)) begin
          bsy = 1'b0;
        end
      end
`endif
    end

    assign rd_data[i*WORD_WIDTH +: WORD_WIDTH] = data;
    assign rd_busy[i] = bsy;
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench for scoreboard_regfile.
// Directed scenarios plus randomized traffic against an array model.
module tb_scoreboard_regfile;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_busy;
  logic          wr0_en, wr1_en, rsv_en, flush;
  logic [AW-1:0] wr0_addr, wr1_addr, rsv_addr;
  logic [W-1:0]  wr0_data, wr1_data;
  logic          rsv_ready;
  logic [AW:0]   busy_cnt;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_reg [D];
  bit           m_busy [D];

  scoreboard_regfile #(
    .WORD_WIDTH (W),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(m_busy[k]);
    return n;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < D; k++) begin
      m_reg[k]  = '0;
      m_busy[k] = 0;
    end
  endtask

  // Spec rules applied to the model at each rising edge
  task automatic m_edge();
    if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] = wr0_data;
    if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] = wr1_data;
    if (flush) begin
      for (int k = 0; k < D; k++) m_busy[k] = 0;
    end else begin
      if (wr1_en) m_busy[wr1_addr] = 0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
  endtask

  function automatic logic [W-1:0] exp_data(logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && wr1_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    wr0_en = 0; wr1_en = 0; rsv_en = 0; flush = 0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) m_edge();
    #1;
    idle();
  endtask

  task automatic set_rd(int p, logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [W-1:0] get_rd(int p);
    return rd_data[p*W +: W];
  endfunction

  task automatic test_reset();
    rst_n = 0;
    idle();
    rd_addr = '0;
    m_reset();
    #12;
    if (busy_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt);
    end
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", rsv_ready);
    end
    checks++;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hDEADBEEF;
    cycle();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    cycle();
    set_rd(1, 3); set_rd(0, 0);
    #1;
    if (get_rd(1) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_r3 got=%h exp=deadbeef", get_rd(1));
    end
    checks++;
    if (get_rd(0) !== 32'h0 || rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL r0_zero got=%h/%b exp=0/0", get_rd(0), rd_busy[0]);
    end
    checks++;
  endtask

  task automatic test_dual_write();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2;
    cycle();
    set_rd(0, 7);
    #1;
    if (get_rd(0) !== 32'h2) begin
      errors++; $display("FAIL dual_wr got=%h exp=2", get_rd(0));
    end
    checks++;
  endtask

  task automatic test_scoreboard();
    set_rd(0, 9);
    rsv_en = 1; rsv_addr = 9;
    cycle();
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL rsv_r9 got=%b/%0d exp=1/1", rd_busy[0], busy_cnt);
    end
    checks++;
    rsv_addr = 9;
    #1;
    if (rsv_ready !== 1'b0) begin
      errors++; $display("FAIL rsv_ready got=%b exp=0", rsv_ready);
    end
    checks++;
    rsv_en = 1; rsv_addr = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h33;
    cycle();
    if (rd_busy[0] !== 1'b1 || get_rd(0) !== 32'h33) begin
      errors++; $display("FAIL rsv_wins got=%b/%h exp=1/33", rd_busy[0], get_rd(0));
    end
    checks++;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h55;
    cycle();
    if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || get_rd(0) !== 32'h55) begin
      errors++;
      $display("FAIL wr1_clear got=%b/%0d/%h exp=0/0/55", rd_busy[0], busy_cnt, get_rd(0));
    end
    checks++;
    rsv_en = 1; rsv_addr = 0;
    cycle();
    if (busy_cnt !== 6'd0 || rsv_ready !== 1'b1) begin
      errors++; $display("FAIL rsv_r0 got=%0d/%b exp=0/1", busy_cnt, rsv_ready);
    end
    checks++;
  endtask

  task automatic test_flush();
    rsv_en = 1; rsv_addr = 1; cycle();
    rsv_en = 1; rsv_addr = 2; cycle();
    rsv_en = 1; rsv_addr = 4; cycle();
    if (busy_cnt !== 6'd3) begin
      errors++; $display("FAIL pre_flush got=%0d exp=3", busy_cnt);
    end
    checks++;
    flush = 1; rsv_en = 1; rsv_addr = 6;
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'hC0FFEE;
    cycle();
    set_rd(0, 6); set_rd(1, 12);
    #1;
    if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL flush got=%0d/%b exp=0/0", busy_cnt, rd_busy[0]);
    end
    checks++;
    if (get_rd(1) !== 32'hC0FFEE) begin
      errors++; $display("FAIL flush_wr got=%h exp=c0ffee", get_rd(1));
    end
    checks++;
  endtask

  task automatic test_bypass();
    logic [W-1:0] old;
    logic         exp_b;
    logic [W-1:0] exp_d;
    rsv_en = 1; rsv_addr = 10;
    cycle();
    old = m_reg[10];
    set_rd(0, 10);
    wr1_en = 1; wr1_addr = 10; wr1_data = 32'hA5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'hA5; exp_b = 1'b0;
`else
    exp_d = old; exp_b = 1'b1;
`endif
    if (get_rd(0) !== exp_d || rd_busy[0] !== exp_b) begin
      errors++;
      $display("FAIL bypass got=%h/%b exp=%h/%b", get_rd(0), rd_busy[0], exp_d, exp_b);
    end
    checks++;
    cycle();
    if (get_rd(0) !== 32'hA5 || rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL post_byp got=%h/%b exp=a5/0", get_rd(0), rd_busy[0]);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr0_en   = ($urandom_range(0, 1) == 1);
      wr0_addr = AW'($urandom_range(0, 15));
      wr0_data = $urandom;
      wr1_en   = ($urandom_range(0, 2) == 0);
      wr1_addr = AW'($urandom_range(0, 15));
      wr1_data = $urandom;
      rsv_en   = ($urandom_range(0, 1) == 1);
      rsv_addr = AW'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < NR; p++) set_rd(p, AW'($urandom_range(0, 15)));
      #1;
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        if (get_rd(p) !== exp_data(a) || rd_busy[p] !== exp_busy(a)) begin
          errors++;
          $display("FAIL rnd_rd n=%0d p=%0d a=%0d got=%h/%b exp=%h/%b",
                   n, p, a, get_rd(p), rd_busy[p], exp_data(a), exp_busy(a));
        end
        checks++;
      end
      if (rsv_ready !== (rsv_addr == 0 || !m_busy[rsv_addr])) begin
        errors++; $display("FAIL rnd_ready n=%0d got=%b", n, rsv_ready);
      end
      checks++;
      cycle();
      if (int'(busy_cnt) !== m_count()) begin
        errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, m_count());
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234;
    rsv_en = 1; rsv_addr = 11;
    cycle();
    set_rd(0, 5); set_rd(1, 11);
    #1;
    if (get_rd(0) !== 32'h1234 || busy_cnt === '0) begin
      errors++; $display("FAIL pre_rst got=%h/%0d exp=1234/nonzero", get_rd(0), busy_cnt);
    end
    checks++;
    rst_n = 0;
    m_reset();
    #1;
    if (get_rd(0) !== 32'h0 || busy_cnt !== '0 || rd_busy !== '0) begin
      errors++;
      $display("FAIL async_rst got=%h/%0d/%b exp=0/0/00", get_rd(0), busy_cnt, rd_busy);
    end
    checks++;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h77;
    rsv_en = 1; rsv_addr = 5;
    @(posedge clk);
    #1;
    idle();
    if (get_rd(0) !== 32'h0 || busy_cnt !== '0) begin
      errors++; $display("FAIL rst_hold got=%h/%0d exp=0/0", get_rd(0), busy_cnt);
    end
    checks++;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
# scoreboard_regfile

Parametrised general-purpose register file with per-register pending (scoreboard) bits. It is the next-generation replacement for the CPU's two-read/one-write register file. It adds a configurable number of read ports, two write ports (ALU writeback and load writeback), asynchronous reset of all state, and destination reservation so decode can detect RAW hazards against in-flight loads. It sits between decode (reads, reserve) and the writeback stage.

## Interface
Parameters:
- WORD_WIDTH, default `WORD_WIDTH (32): register data width.
- ADDR_WIDTH, default 5: register index width; depth = 2**ADDR_WIDTH.
- NUM_READ, default 2, legal 1–4: number of combinational read ports.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*WORD_WIDTH  read data, same packing.
- rd_busy  out  NUM_READ  pending bit of each read address.
- wr0_en / wr0_addr / wr0_data  in  1 / ADDR_WIDTH / WORD_WIDTH  ALU writeback port.
- wr1_en / wr1_addr / wr1_data  in  1 / ADDR_WIDTH / WORD_WIDTH  load writeback port; also clears the pending bit.
- rsv_en / rsv_addr  in  1 / ADDR_WIDTH  mark the destination as pending.
- rsv_ready  out  1  rsv_addr currently not pending (combinational).
- flush  in  1  synchronous clear of all pending bits.
- busy_cnt  out  ADDR_WIDTH+1  registered count of pending registers.

## Operation
- Register 0 is hardwired zero:
  - Reads return 0 and rd_busy 0.
  - Writes to it are ignored.
  - Reserving it is ignored; rsv_ready is 1 when rsv_addr = 0.
- Reads are combinational: rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
- Writes occur on the rising edge when the port's enable is high.
- Both write ports target the same nonzero address in one cycle: wr1 data is stored, wr0 is dropped.
- Pending bit update per edge, priority high to low:
  - flush: all busy bits ← 0; a same-cycle rsv_en is discarded.
  - rsv_en: busy[rsv_addr] ← 1. This wins over a same-cycle wr1 clear of the same address; the data write still happens.
  - wr1_en: busy[wr1_addr] ← 0.
- wr0 never changes busy bits.
- Reserving an already-pending register is legal; the bit stays 1 (no count of outstanding reservations).
- Writes are performed during flush.
- busy_cnt equals the popcount of the busy vector after each edge.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_cnt 0.
  - rd_data, rd_busy and rsv_ready follow combinationally: 0 / 0 / 1.
  - Reset asserted mid-operation discards any same-cycle write or reserve.
- Write latency: data is visible on rd_data the cycle after the write edge (without bypass).
- Reserve latency: rd_busy rises the cycle after the rsv_en edge; busy_cnt updates on the same edge.
- rsv_ready has no same-cycle bypass of rsv_en or wr1_en.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose nonzero address matches an active write port this cycle returns that write's data (wr1 over wr0). rd_busy is forced 0 when wr1_en clears the same address this cycle, unless a same-cycle rsv_en targets it.
- REGFILE_BYPASS_EN undefined: reads return stored state only; there is no combinational path from write ports to read outputs.

## Structure
- `WORD_WIDTH and the default register-index width belong in the shared constants.v, alongside the existing CPU constants.
- The popcount of the busy vector is a natural sub-module, busy_popcount (parametrised on vector width), producing the next busy_cnt value.
- The storage array and scoreboard stay in the top module.

## Test plan
- Reset: assert rst_n low mid-stream after writing r5=0x1234 → rd_data 0 and busy_cnt 0 immediately, with no clock edge needed.
- Write/read: wr0 r3=0xDEADBEEF, then read r3 on port 1 → 0xDEADBEEF next cycle; write r0=0xFFFFFFFF → r0 reads 0.
- Dual write conflict: wr0 r7=0x1, wr1 r7=0x2 in the same cycle → r7 reads 0x2.
- Scoreboard:
  - rsv r9 → rd_busy 1 and busy_cnt 1.
  - Reserve r9 plus wr1 r9 in the same cycle → still busy.
  - wr1 r9=0x55 alone → busy 0, busy_cnt 0, data 0x55.
- Flush: reserve r1, r2, r4, then flush with a concurrent rsv r6 → busy_cnt 0 and r6 not busy.
- Bypass (REGFILE_BYPASS_EN): reserve r10; wr1 r10=0xA5 while reading r10 → same-cycle rd_data 0xA5 and rd_busy 0. Without the macro → old value and busy 1 that cycle.
